// File: rtl/reg_write_arbiter_if.sv
// Requester-side bundle for reg_write_arbiter: request/lock/data in, grant and
// shared-register status out.
interface reg_write_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       lock;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       gnt;
    logic [WIDTH-1:0]       q;
    logic [3:0]             owner;
    logic                   locked;
    logic                   lock_timeout;
    logic [15:0]            wr_count;

    modport master (
        output req, lock, wdata,
        input  gnt, q, owner, locked, lock_timeout, wr_count
    );

    modport slave (
        input  req, lock, wdata,
        output gnt, q, owner, locked, lock_timeout, wr_count
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for one shared WIDTH-bit register, with a bounded
// per-requester lock that grants exclusive back-to-back writes.
module reg_write_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_LOCK = 8
) (
    input logic                 clk,
    input logic                 reset,
    reg_write_arbiter_if.slave  bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Closest requester at or after the pointer; MSB flags that one was found.
    function automatic logic [PW:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [PW-1:0]    p);
        logic [PW:0]   res;
        logic [PW-1:0] ci;
        int            idx;
        res = {(PW+1){1'b0}};
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(p) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end else begin
                idx = idx;
            end
            ci = PW'(idx);
            if (r[ci]) begin
                res = {1'b1, ci};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [N_REQ-1:0] one_hot(input logic [PW-1:0] s);
        logic [N_REQ-1:0] oh;
        for (int i = 0; i < N_REQ; i++) begin
            oh[i] = (PW'(i) == s);
        end
        return oh;
    endfunction

    logic [0:0]       state_r, state_s;
    logic [PW-1:0]    ptr_r, ptr_s;
    logic [7:0]       lcnt_r, lcnt_s;
    logic [N_REQ-1:0] lockout_r, lockout_s;
    logic [WIDTH-1:0] q_r, q_s;
    logic [N_REQ-1:0] gnt_r, gnt_s;
    logic [3:0]       owner_r, owner_s;
    logic             locked_r;
    logic             timeout_r, timeout_s;
    logic [15:0]      wr_count_r, wr_count_s;

    logic [PW:0]      pick_s;
    logic [PW-1:0]    sel_s;
    logic [PW-1:0]    own_s;

    assign pick_s = rr_pick(bus.req, ptr_r);
    assign sel_s  = pick_s[PW-1:0];
    assign own_s  = owner_r[PW-1:0];

    // Next-state arbitration: round-robin pick in IDLE, owner-only service in LOCKED.
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        lcnt_s     = lcnt_r;
        owner_s    = owner_r;
        q_s        = q_r;
        gnt_s      = {N_REQ{1'b0}};
        wr_count_s = wr_count_r;
        timeout_s  = 1'b0;
        // Lockout only survives while the requester keeps asking for a lock.
        lockout_s  = lockout_r & bus.lock;
        case (state_r)
            ST_IDLE: begin
                if (pick_s[PW]) begin
                    q_s        = bus.wdata[sel_s*WIDTH +: WIDTH];
                    gnt_s      = one_hot(sel_s);
                    ptr_s      = (int'(sel_s) == N_REQ - 1) ? {PW{1'b0}} : sel_s + 1'b1;
                    wr_count_s = wr_count_r + 16'd1;
                    if (bus.lock[sel_s] && !lockout_r[sel_s]) begin
                        state_s = ST_LOCKED;
                        owner_s = 4'(sel_s);
                        lcnt_s  = 8'd1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    gnt_s = {N_REQ{1'b0}};
                end
            end
            ST_LOCKED: begin
                if (bus.req[own_s]) begin
                    q_s        = bus.wdata[own_s*WIDTH +: WIDTH];
                    gnt_s      = one_hot(own_s);
                    wr_count_s = wr_count_r + 16'd1;
                end else begin
                    gnt_s = {N_REQ{1'b0}};
                end
                if (!bus.lock[own_s]) begin
                    state_s = ST_IDLE;
                end else if (lcnt_r == 8'(MAX_LOCK)) begin
                    state_s          = ST_IDLE;
                    timeout_s        = 1'b1;
                    lockout_s[own_s] = 1'b1;
                end else begin
                    lcnt_s = lcnt_r + 8'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; a low reset at the edge wins over any request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            ptr_r      <= {PW{1'b0}};
            lcnt_r     <= 8'd0;
            lockout_r  <= {N_REQ{1'b0}};
            q_r        <= {WIDTH{1'b0}};
            gnt_r      <= {N_REQ{1'b0}};
            owner_r    <= 4'd0;
            locked_r   <= 1'b0;
            timeout_r  <= 1'b0;
            wr_count_r <= 16'd0;
        end else begin
            state_r    <= state_s;
            ptr_r      <= ptr_s;
            lcnt_r     <= lcnt_s;
            lockout_r  <= lockout_s;
            q_r        <= q_s;
            gnt_r      <= gnt_s;
            owner_r    <= owner_s;
            locked_r   <= (state_s == ST_LOCKED);
            timeout_r  <= timeout_s;
            wr_count_r <= wr_count_s;
        end
    end

    assign bus.gnt          = gnt_r;
    assign bus.q            = q_r;
    assign bus.owner        = owner_r;
    assign bus.locked       = locked_r;
    assign bus.lock_timeout = timeout_r;
    assign bus.wr_count     = wr_count_r;
endmodule
